// File: rtl/game_mode_sequencer.sv
// Top-level game flow FSM for the chicken memory game: drives mode bus M to the phase timer and keeps score/lives.
// Transitions act on edges of C and btn_start, so held levels never re-trigger; turn timeout exists only with GAME_SEQ_TURN_TIMEOUT_EN.
module game_mode_sequencer #(
  parameter int unsigned LIVES        = 3,
  parameter int unsigned WIN_SCORE    = 8,
  parameter logic [31:0] TURN_TIMEOUT = 32'd500000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       C,
  input  logic       btn_start,
  input  logic       guess_valid,
  input  logic       guess_hit,
  output logic [2:0] M,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       win
);

  typedef enum logic [2:0] {
    INTRO      = 3'b000,
    WAIT_START = 3'b001,
    REVEAL     = 3'b010,
    TURN       = 3'b011,
    LOSE       = 3'b100,
    HIT        = 3'b101,
    MISS       = 3'b110,
    WIN        = 3'b111
  } mode_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [3:0] WIN_TARGET = 4'(WIN_SCORE);

  mode_t      state;
  mode_t      state_nxt;
  logic [3:0] score_nxt;
  logic [1:0] lives_nxt;
  logic       c_q;
  logic       start_q;
  logic       c_rise;
  logic       start_rise;
  logic       timeout;

  assign c_rise     = C & ~c_q;
  assign start_rise = btn_start & ~start_q;
  assign M          = state;

`ifdef GAME_SEQ_TURN_TIMEOUT_EN
  logic [31:0] turn_cnt;

  // A guess landing on the final cycle wins over the timeout.
  assign timeout = (state == TURN) && (turn_cnt == TURN_TIMEOUT - 32'd1) && !guess_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      turn_cnt <= 32'd0;
    end else if (state_nxt == TURN && state != TURN) begin
      turn_cnt <= 32'd0;
    end else if (state == TURN) begin
      turn_cnt <= turn_cnt + 32'd1;
    end
  end
`else
  logic unused_timeout;

  assign timeout        = 1'b0;
  assign unused_timeout = ^TURN_TIMEOUT;
`endif

  // Every timed mode exits to an untimed one, letting the timer drop a stale C.
  always_comb begin
    state_nxt = state;
    score_nxt = score;
    lives_nxt = lives;
    case (state)
      INTRO: begin
        if (c_rise) state_nxt = WAIT_START;
      end
      WAIT_START: begin
        if (start_rise) begin
          state_nxt = REVEAL;
          score_nxt = 4'd0;
          lives_nxt = LIVES_INIT;
        end
      end
      REVEAL: begin
        if (c_rise) state_nxt = TURN;
      end
      TURN: begin
        if (guess_valid && guess_hit) begin
          state_nxt = HIT;
          score_nxt = (score == 4'd15) ? score : score + 4'd1;
        end else if (guess_valid || timeout) begin
          state_nxt = MISS;
          lives_nxt = (lives == 2'd0) ? lives : lives - 2'd1;
        end
      end
      HIT: begin
        if (c_rise) state_nxt = (score == WIN_TARGET) ? WIN : TURN;
      end
      MISS: begin
        if (c_rise) state_nxt = (lives == 2'd0) ? LOSE : TURN;
      end
      LOSE, WIN: begin
        if (start_rise) begin
          state_nxt = INTRO;
          score_nxt = 4'd0;
          lives_nxt = LIVES_INIT;
        end
      end
      default: state_nxt = INTRO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INTRO;
      score     <= 4'd0;
      lives     <= LIVES_INIT;
      game_over <= 1'b0;
      win       <= 1'b0;
      c_q       <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      state     <= state_nxt;
      score     <= score_nxt;
      lives     <= lives_nxt;
      game_over <= (state_nxt == LOSE);
      win       <= (state_nxt == WIN);
      c_q       <= C;
      start_q   <= btn_start;
    end
  end

endmodule

// File: tb/tb_game_mode_sequencer.sv
// Scoreboard bench: behavioural game model predicts mode/score/lives every cycle; a monitor compares after each edge.
module tb_game_mode_sequencer;

  localparam int LIVES = 3;
  localparam int WIN_SCORE = 8;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       C = 1'b0;
  logic       btn_start = 1'b0;
  logic       guess_valid = 1'b0;
  logic       guess_hit = 1'b0;
  logic [2:0] M;
  logic [3:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       win;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_mode_sequencer #(
    .LIVES(LIVES),
    .WIN_SCORE(WIN_SCORE),
    .TURN_TIMEOUT(32'(TO))
  ) dut (
    .clk(clk),
    .rst(rst),
    .C(C),
    .btn_start(btn_start),
    .guess_valid(guess_valid),
    .guess_hit(guess_hit),
    .M(M),
    .score(score),
    .lives(lives),
    .game_over(game_over),
    .win(win)
  );

  typedef enum {P_INTRO, P_WAIT, P_REVEAL, P_TURN, P_HIT, P_MISS, P_LOSE, P_WIN} phase_e;

  phase_e ph = P_INTRO;
  int     sc = 0;
  int     lv = LIVES;
  bit     prev_c = 1'b0;
  bit     prev_s = 1'b0;
  int     turn_age = 0;

  logic [10:0] exp_q[$];

  function automatic logic [2:0] mode_code(input phase_e p);
    case (p)
      P_INTRO:  return 3'b000;
      P_WAIT:   return 3'b001;
      P_REVEAL: return 3'b010;
      P_TURN:   return 3'b011;
      P_HIT:    return 3'b101;
      P_MISS:   return 3'b110;
      P_LOSE:   return 3'b100;
      default:  return 3'b111;
    endcase
  endfunction

  task automatic enter_turn();
    ph = P_TURN;
    turn_age = 0;
  endtask

  task automatic model_step(input bit c, input bit st, input bit gv, input bit gh, input bit r);
    bit cr;
    bit sr;
    if (r) begin
      ph = P_INTRO; sc = 0; lv = LIVES; prev_c = 0; prev_s = 0; turn_age = 0;
    end else begin
      cr = c && !prev_c;
      sr = st && !prev_s;
      prev_c = c;
      prev_s = st;
      case (ph)
        P_INTRO:  if (cr) ph = P_WAIT;
        P_WAIT:   if (sr) begin ph = P_REVEAL; sc = 0; lv = LIVES; end
        P_REVEAL: if (cr) enter_turn();
        P_TURN: begin
          if (gv && gh) begin
            ph = P_HIT; sc = (sc < 15) ? sc + 1 : 15;
          end else if (gv) begin
            ph = P_MISS; lv = (lv > 0) ? lv - 1 : 0;
          end
`ifdef GAME_SEQ_TURN_TIMEOUT_EN
          else if (turn_age == TO - 1) begin
            ph = P_MISS; lv = (lv > 0) ? lv - 1 : 0;
          end else begin
            turn_age++;
          end
`endif
        end
        P_HIT:  if (cr) begin if (sc == WIN_SCORE) ph = P_WIN; else enter_turn(); end
        P_MISS: if (cr) begin if (lv == 0) ph = P_LOSE; else enter_turn(); end
        default: if (sr) begin ph = P_INTRO; sc = 0; lv = LIVES; end
      endcase
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic step(input bit c, input bit st, input bit gv, input bit gh, input bit r);
    @(negedge clk);
    C = c; btn_start = st; guess_valid = gv; guess_hit = gh; rst = r;
    model_step(c, st, gv, gh, r);
    exp_q.push_back({mode_code(ph), 4'(sc), 2'(lv), ph == P_LOSE, ph == P_WIN});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic c_pulse();
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic s_pulse();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic guess(input bit hit);
    step(0, 0, 1, hit, 0);
  endtask

  initial begin : monitor
    logic [10:0] e;
    logic [10:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        a = {M, score, lives, game_over, win};
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL state t=%0t got M=%b score=%0d lives=%0d go=%b win=%b, expected M=%b score=%0d lives=%0d go=%b win=%b",
                   $time, a[10:8], a[7:4], a[3:2], a[1], a[0], e[10:8], e[7:4], e[3:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    bit rc, rs, rg;
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    c_pulse();                          // INTRO -> WAIT_START
    s_pulse();                          // -> REVEAL
    c_pulse();                          // -> TURN
    for (int i = 0; i < WIN_SCORE; i++) begin
      guess(1);
      c_pulse();
    end
    s_pulse();                          // WIN -> INTRO
    c_pulse();
    s_pulse();
    c_pulse();
    for (int i = 0; i < LIVES; i++) begin
      guess(0);
      c_pulse();
    end
    idle(2);
    s_pulse();                          // LOSE -> INTRO

    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    guess(1);                           // ignored in WAIT_START
    s_pulse();
    c_pulse();
    step(0, 1, 1, 1, 0);                // guess wins over start
    step(0, 0, 0, 0, 0);
    c_pulse();
    for (int i = 0; i < 4; i++) begin
      guess(1);
      if (i < 3) c_pulse();
    end
    idle(1);
    step(0, 0, 0, 0, 1);                // reset from HIT with score 5
    idle(2);

`ifdef GAME_SEQ_TURN_TIMEOUT_EN
    c_pulse();
    s_pulse();
    c_pulse();
    idle(TO + 3);
    c_pulse();
    idle(TO - 2);
    guess(1);                           // guess on the timeout cycle
    idle(3);
`endif

    rc = 0; rs = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) rc = ~rc;
      if ($urandom_range(0, 5) == 0) rs = ~rs;
      rg = ($urandom_range(0, 4) == 0);
      step(rc, rs, rg, $urandom_range(0, 3) != 0, $urandom_range(0, 999) == 0);
    end

    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
